ifetch_pc_gen: RTL and testbench



---
 rtl/ifetch_pc_gen_if.sv | 26 ++
 rtl/ifetch_pc_gen.sv | 110 +++++++++++
 tb/tb_ifetch_pc_gen.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ifetch_pc_gen_if.sv
// Fetch-side bundle of the next-PC generator: stall and redirect requests in,
// and the registered fetch address with its status flags out.
interface ifetch_pc_gen_if #(
  parameter int B     = 32,
  parameter int NSRC  = 4,
  parameter int CNT_W = 16
);
  logic              stall;
  logic [NSRC-1:0]   src_vld;
  logic [NSRC*B-1:0] src_pc;
  logic [B-1:0]      pc;
  logic              pc_valid;
  logic              pend_vld;
  logic              align_err;
  logic [CNT_W-1:0]  redir_cnt;

  modport master (
    output stall, src_vld, src_pc,
    input  pc, pc_valid, pend_vld, align_err, redir_cnt
  );

  modport slave (
    input  stall, src_vld, src_pc,
    output pc, pc_valid, pend_vld, align_err, redir_cnt
  );
endinterface

// File: rtl/ifetch_pc_gen.sv
// Registered next-PC generator for IFETCH: prioritised redirect select, a
// stall-aware pending-redirect buffer, alignment enforcement and a redirect counter.
module ifetch_pc_gen #(
  parameter int             B          = 32,
  parameter int             NSRC       = 4,
  parameter int             INC        = 4,
  parameter logic [B-1:0]   RESET_VEC  = '0,
  parameter int             ALIGN_BITS = 2,
  parameter int             CNT_W      = 16
) (
  input logic            clk,
  input logic            rst_n,
  ifetch_pc_gen_if.slave bus
);

  typedef enum logic [1:0] {BOOT, RUN, HELD} state_t;

  localparam logic [B-1:0] ALIGN_MASK = ~({B{1'b1}} << ALIGN_BITS);

  state_t           state_q, state_nx;
  logic [B-1:0]     pc_q, pc_nx;
  logic [B-1:0]     pend_q, pend_nx;
  logic             err_q, err_nx;
  logic [CNT_W-1:0] cnt_q;
  logic             apply;

  logic             win_vld;
  logic [B-1:0]     win_raw;
  logic [B-1:0]     win_tgt;
  logic             win_mis;

  // Scan from the lowest priority upwards so the lowest valid index is the last write.
  always_comb begin
    win_vld = 1'b0;
    win_raw = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (bus.src_vld[i]) begin
        win_vld = 1'b1;
        win_raw = bus.src_pc[i*B +: B];
      end
    end
  end

  assign win_tgt = win_raw & ~ALIGN_MASK;
  assign win_mis = |(win_raw & ALIGN_MASK);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_nx = state_q;
    pc_nx    = pc_q;
    pend_nx  = pend_q;
    err_nx   = 1'b0;
    apply    = 1'b0;
    unique case (state_q)
      BOOT: state_nx = RUN;
      RUN: begin
        if (!bus.stall) begin
          if (win_vld) begin
            pc_nx  = win_tgt;
            apply  = 1'b1;
            err_nx = win_mis;
          end else begin
            pc_nx = pc_q + B'(INC);
          end
        end else if (win_vld) begin
          pend_nx  = win_tgt;
          err_nx   = win_mis;
          state_nx = HELD;
        end
      end
      HELD: begin
        err_nx = win_vld & win_mis;
        if (bus.stall) begin
          if (win_vld) pend_nx = win_tgt;
        end else begin
          // The exit slot always carries a redirect: a fresh winner beats the buffered one.
          pc_nx    = win_vld ? win_tgt : pend_q;
          apply    = 1'b1;
          state_nx = RUN;
        end
      end
      default: state_nx = BOOT;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      pend_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      pc_q    <= pc_nx;
      pend_q  <= pend_nx;
      err_q   <= err_nx;
      if (apply && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Status flags decode the state register only, so outputs never see inputs combinationally.
  assign bus.pc        = pc_q;
  assign bus.pc_valid  = (state_q != BOOT);
  assign bus.pend_vld  = (state_q == HELD);
  assign bus.align_err = err_q;
  assign bus.redir_cnt = cnt_q;

endmodule

// File: tb/tb_ifetch_pc_gen.sv
// Directed self-checking bench for ifetch_pc_gen: a default instance and a
// 2-bit-counter instance used for saturation and mid-HELD reset.
module tb_ifetch_pc_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ifetch_pc_gen_if #(.B(32), .NSRC(4), .CNT_W(16)) bus  ();
  ifetch_pc_gen_if #(.B(32), .NSRC(4), .CNT_W(2))  bus2 ();

  ifetch_pc_gen #(.B(32), .NSRC(4), .INC(4), .RESET_VEC(32'h0),
                  .ALIGN_BITS(2), .CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ifetch_pc_gen #(.B(32), .NSRC(4), .INC(4), .RESET_VEC(32'h0),
                  .ALIGN_BITS(2), .CNT_W(2)) u_sat (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it before driving or checking.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int idx, input logic [31:0] tgt);
    bus.src_vld = '0;
    bus.src_vld[idx] = 1'b1;
    bus.src_pc[idx*32 +: 32] = tgt;
  endtask

  initial begin
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    bus.stall   = 1'b0;
    bus.src_vld = '0;
    bus.src_pc  = '0;
    bus2.stall   = 1'b0;
    bus2.src_vld = '0;
    bus2.src_pc  = '0;
    #1;
    check("rst_pc",       bus.pc, 32'h0);
    check("rst_pc_valid", 32'(bus.pc_valid), 32'd0);
    check("rst_pend",     32'(bus.pend_vld), 32'd0);
    check("rst_cnt",      32'(bus.redir_cnt), 32'd0);
    check("rst_err",      32'(bus.align_err), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // Boot cycle then sequential fetch, with a request ignored during BOOT.
    req(1, 32'h0000_0800);
    check("boot_pc_valid", 32'(bus.pc_valid), 32'd0);
    step();
    bus.src_vld = '0;
    check("run_pc_valid", 32'(bus.pc_valid), 32'd1);
    check("seq_pc0", bus.pc, 32'h0);
    check("boot_cnt", 32'(bus.redir_cnt), 32'd0);
    step(); check("seq_pc4", bus.pc, 32'h4);
    step(); check("seq_pc8", bus.pc, 32'h8);
    step(); check("seq_pcC", bus.pc, 32'hC);
    check("seq_cnt", 32'(bus.redir_cnt), 32'd0);

    // Priority: sources 1 and 2 both request, source 1 wins.
    bus.src_vld = 4'b0110;
    bus.src_pc[1*32 +: 32] = 32'h100;
    bus.src_pc[2*32 +: 32] = 32'h200;
    step();
    bus.src_vld = '0;
    check("prio_pc",  bus.pc, 32'h100);
    check("prio_cnt", 32'(bus.redir_cnt), 32'd1);
    step(); check("prio_next", bus.pc, 32'h104);

    // Stall with two redirects; the newer one is applied on release.
    bus.stall = 1'b1;
    req(3, 32'h400);
    step();
    check("hold1_pc",   bus.pc, 32'h104);
    check("hold1_pend", 32'(bus.pend_vld), 32'd1);
    check("hold1_cnt",  32'(bus.redir_cnt), 32'd1);
    req(1, 32'h500);
    step();
    check("hold2_pc",    bus.pc, 32'h104);
    check("hold2_valid", 32'(bus.pc_valid), 32'd1);
    bus.src_vld = '0;
    step();
    check("hold3_pc",   bus.pc, 32'h104);
    check("hold3_pend", 32'(bus.pend_vld), 32'd1);
    bus.stall = 1'b0;
    step();
    check("rel_pc",   bus.pc, 32'h500);
    check("rel_pend", 32'(bus.pend_vld), 32'd0);
    check("rel_cnt",  32'(bus.redir_cnt), 32'd2);
    step(); check("rel_next", bus.pc, 32'h504);

    // Misaligned applied target.
    req(0, 32'h203);
    step();
    bus.src_vld = '0;
    check("mis_pc",  bus.pc, 32'h200);
    check("mis_err", 32'(bus.align_err), 32'd1);
    check("mis_cnt", 32'(bus.redir_cnt), 32'd3);
    step();
    check("mis_err_clr", 32'(bus.align_err), 32'd0);
    check("mis_next",    bus.pc, 32'h204);

    // Misaligned captured target.
    bus.stall = 1'b1;
    req(2, 32'h301);
    step();
    check("cap_err",  32'(bus.align_err), 32'd1);
    check("cap_pc",   bus.pc, 32'h204);
    bus.stall = 1'b0;
    bus.src_vld = '0;
    step();
    check("cap_rel_pc",  bus.pc, 32'h300);
    check("cap_rel_err", 32'(bus.align_err), 32'd0);
    check("cap_rel_cnt", 32'(bus.redir_cnt), 32'd4);

    // An incoming winner on the HELD exit cycle beats the buffered target.
    bus.stall = 1'b1;
    req(1, 32'h600);
    step();
    bus.stall = 1'b0;
    req(1, 32'h700);
    step();
    bus.src_vld = '0;
    check("exit_win_pc",   bus.pc, 32'h700);
    check("exit_win_cnt",  32'(bus.redir_cnt), 32'd5);
    check("exit_win_pend", 32'(bus.pend_vld), 32'd0);

    // Wrap modulo 2^32.
    req(0, 32'hFFFF_FFFC);
    step();
    bus.src_vld = '0;
    check("wrap_top", bus.pc, 32'hFFFF_FFFC);
    step(); check("wrap_zero", bus.pc, 32'h0);
    step(); check("wrap_four", bus.pc, 32'h4);

    // Saturating counter on the CNT_W=2 instance.
    rst2_n = 1'b1;
    step();
    check("sat_valid", 32'(bus2.pc_valid), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      bus2.src_vld = 4'b0001;
      bus2.src_pc[31:0] = 32'(k * 16);
      step();
      check($sformatf("sat_pc%0d", k), bus2.pc, 32'(k * 16));
      check($sformatf("sat_cnt%0d", k), 32'(bus2.redir_cnt), (k < 3) ? 32'(k) : 32'd3);
    end

    // Reset while HELD discards the pending redirect.
    bus2.stall = 1'b1;
    bus2.src_vld = 4'b0001;
    bus2.src_pc[31:0] = 32'h800;
    step();
    check("sat_held_pend", 32'(bus2.pend_vld), 32'd1);
    rst2_n = 1'b0;
    #1;
    check("midrst_pc",    bus2.pc, 32'h0);
    check("midrst_pend",  32'(bus2.pend_vld), 32'd0);
    check("midrst_cnt",   32'(bus2.redir_cnt), 32'd0);
    check("midrst_valid", 32'(bus2.pc_valid), 32'd0);
    bus2.stall = 1'b0;
    bus2.src_vld = '0;
    step();
    rst2_n = 1'b1;
    check("midrst_boot", 32'(bus2.pc_valid), 32'd0);
    step();
    check("midrst_run", 32'(bus2.pc_valid), 32'd1);
    check("midrst_pc0", bus2.pc, 32'h0);
    step();
    check("midrst_pc4", bus2.pc, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
